// File: rtl/counter_mod_n.sv
// counter_mod_n: synchronous modulo-N up/down counter with parallel load,
// count enable, terminal-count / cascade outputs and a sticky overflow flag.
// MODULUS may be any value in 2..2**WIDTH; with MODULUS = 2**WIDTH the wrap
// is plain binary roll-over. SATURATE selects hold-at-end instead of wrap.
module counter_mod_n #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 10,
  parameter int SATURATE = 0
) (
  input  logic             C,
  input  logic             CLR,
  input  logic             CE,
  input  logic             UP,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             CEO,
  output logic             OVF
);

  // Last value of the count sequence; always fits in WIDTH bits.
  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);
  localparam logic             SAT  = (SATURATE != 0);

  logic [WIDTH-1:0] q_p0;
  logic             ovf_p0;
  logic             tc;

  // Load value limiter: anything past the end of the sequence becomes LAST,
  // so an out-of-range value can never be stored.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] d);
    if (d > LAST) return LAST;
    return d;
  endfunction

  // Next count for an enabled step. At a sequence end the count either
  // wraps to the other end or holds there, depending on SATURATE.
  function automatic logic [WIDTH-1:0] step_count(input logic [WIDTH-1:0] q,
                                                  input logic up);
    if (up) begin
      if (q == LAST) return SAT ? q : '0;
      return q + WIDTH'(1);
    end
    if (q == '0) return SAT ? q : LAST;
    return q - WIDTH'(1);
  endfunction

  // Terminal count depends only on the current count and direction.
  always_comb begin
    tc = UP ? (q_p0 == LAST) : (q_p0 == '0);
  end

  // ---- stage p0: count and overflow registers ----
  // Priority CLR > LOAD > CE; OVF is set by any enabled step taken at the
  // terminal count and is cleared only by CLR.
  always_ff @(posedge C) begin
    if (CLR) begin
      q_p0   <= '0;
      ovf_p0 <= 1'b0;
    end else if (LOAD) begin
      q_p0   <= clamp_load(D);
    end else if (CE) begin
      q_p0   <= step_count(q_p0, UP);
      if (tc) ovf_p0 <= 1'b1;
    end
  end

  assign Q   = q_p0;
  assign OVF = ovf_p0;
  assign TC  = tc;
  // Zero-latency cascade enable: the next digit steps on the same edge.
  assign CEO = CE & tc;

endmodule

// File: tb/tb_counter_mod_n.sv
// Bench for counter_mod_n: a wrap instance and a saturate instance share the
// same stimulus; a two-digit cascade runs alongside as a decimal 0..99 counter.
module tb_counter_mod_n;

  logic       clk = 1'b0;
  logic       clr, ce, up, load;
  logic [3:0] d;
  logic       cclr, cce;
  logic       one = 1'b1;
  logic       zero = 1'b0;
  logic [3:0] dz = 4'd0;

  logic [3:0] q_w, q_s, lo_q, hi_q;
  logic       tc_w, ceo_w, ovf_w;
  logic       tc_s, ceo_s, ovf_s;
  logic       lo_tc, lo_ceo, lo_ovf, hi_tc, hi_ceo, hi_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  // reference state
  int mq_w, mo_w, mq_s, mo_s, cnt;
  bit valid  = 1'b0;
  bit cvalid = 1'b0;

  always #50 clk = ~clk;

  counter_mod_n #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_wrap (
    .C(clk), .CLR(clr), .CE(ce), .UP(up), .LOAD(load), .D(d),
    .Q(q_w), .TC(tc_w), .CEO(ceo_w), .OVF(ovf_w));

  counter_mod_n #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_sat (
    .C(clk), .CLR(clr), .CE(ce), .UP(up), .LOAD(load), .D(d),
    .Q(q_s), .TC(tc_s), .CEO(ceo_s), .OVF(ovf_s));

  counter_mod_n #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_lo (
    .C(clk), .CLR(cclr), .CE(cce), .UP(one), .LOAD(zero), .D(dz),
    .Q(lo_q), .TC(lo_tc), .CEO(lo_ceo), .OVF(lo_ovf));

  counter_mod_n #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_hi (
    .C(clk), .CLR(cclr), .CE(lo_ceo), .UP(one), .LOAD(zero), .D(dz),
    .Q(hi_q), .TC(hi_tc), .CEO(hi_ceo), .OVF(hi_ovf));

  task automatic check(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Behavioural rule for one edge of a modulo-10 digit.
  task automatic model_edge(inout int q, inout int o, input bit sat,
                            input bit iclr, input bit ice, input bit iup,
                            input bit iload, input int id);
    if (iclr) begin
      q = 0; o = 0;
    end else if (iload) begin
      q = (id > 9) ? 9 : id;
    end else if (ice) begin
      if (iup) begin
        if (q == 9) begin o = 1; q = sat ? 9 : 0; end
        else q = q + 1;
      end else begin
        if (q == 0) begin o = 1; q = sat ? 0 : 9; end
        else q = q - 1;
      end
    end
  endtask

  // One clock: apply inputs, check combinational outputs, clock, check state.
  task automatic step(input bit iclr, input bit ice, input bit iup,
                      input bit iload, input int id,
                      input bit icclr, input bit icce);
    int etc;
    clr = iclr; ce = ice; up = iup; load = iload; d = 4'(id);
    cclr = icclr; cce = icce;
    #1;
    if (valid) begin
      etc = iup ? int'(mq_w == 9) : int'(mq_w == 0);
      check("tc_wrap", tc_w, etc);
      check("ceo_wrap", ceo_w, ice ? etc : 0);
      etc = iup ? int'(mq_s == 9) : int'(mq_s == 0);
      check("tc_sat", tc_s, etc);
      check("ceo_sat", ceo_s, ice ? etc : 0);
    end
    if (cvalid) begin
      check("ceo_lo", lo_ceo, (icce && (cnt % 10 == 9)) ? 1 : 0);
    end
    @(posedge clk);
    #1;
    model_edge(mq_w, mo_w, 1'b0, iclr, ice, iup, iload, id);
    model_edge(mq_s, mo_s, 1'b1, iclr, ice, iup, iload, id);
    if (iclr) valid = 1'b1;
    if (icclr) begin cnt = 0; cvalid = 1'b1; end
    else if (icce) cnt = (cnt + 1) % 100;
    if (valid) begin
      check("q_wrap", q_w, mq_w);
      check("ovf_wrap", ovf_w, mo_w);
      check("q_sat", q_s, mq_s);
      check("ovf_sat", ovf_s, mo_s);
    end
    if (cvalid) begin
      check("casc_lo", lo_q, cnt % 10);
      check("casc_hi", hi_q, cnt / 10);
    end
    @(negedge clk);
  endtask

  initial begin
    clr = 0; ce = 0; up = 1; load = 0; d = 0; cclr = 0; cce = 0;
    mq_w = 0; mo_w = 0; mq_s = 0; mo_s = 0; cnt = 0;
    @(negedge clk);

    // reset, then count up through the wrap
    step(1, 0, 1, 0, 0, 1, 0);
    check("rst_q", q_w, 0);
    check("rst_ovf", ovf_w, 0);
    for (int i = 0; i < 12; i++) step(0, 1, 1, 0, 0, 0, 0);
    check("up12_q", q_w, 2);
    check("up12_ovf", ovf_w, 1);

    // down count from zero after a clear
    step(1, 0, 0, 0, 0, 0, 0);
    #1 check("tc_at_zero_down", tc_w, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 0);
    check("down3_q", q_w, 7);

    // loads: in range, clamped, load beats count
    step(0, 0, 1, 1, 7, 0, 0);
    step(0, 0, 1, 1, 13, 0, 0);
    check("load_clamp", q_w, 9);
    step(0, 1, 1, 1, 3, 0, 0);
    check("load_over_ce", q_w, 3);
    step(0, 1, 1, 1, 15, 0, 0);

    // clear beats load and count, counting resumes afterwards
    step(0, 0, 1, 1, 5, 0, 0);
    step(1, 1, 1, 1, 8, 0, 0);
    check("clr_wins_q", q_w, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    check("resume_q", q_w, 1);

    // saturate behaviour at both ends
    step(0, 0, 1, 1, 8, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 0, 0);
    check("sat_top", q_s, 9);
    check("sat_ovf", ovf_s, 1);
    step(0, 0, 1, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 0);
    check("sat_bottom", q_s, 0);

    // hold with CE=0
    for (int i = 0; i < 4; i++) step(0, 0, i[0], 0, 0, 0, 0);

    // cascade: 25 counts from zero
    step(1, 0, 1, 0, 0, 1, 0);
    for (int i = 0; i < 25; i++) step(0, 0, 1, 0, 0, 0, 1);
    check("casc_25", int'(hi_q) * 10 + int'(lo_q), 25);

    // randomized mix
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 39) == 0),
           ($urandom_range(0, 3) != 0),
           $urandom_range(0, 1),
           ($urandom_range(0, 7) == 0),
           $urandom_range(0, 15),
           ($urandom_range(0, 99) == 0),
           ($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
